// File: rtl/intv_cart_pkg.sv
// Shared types and the MAP segment tables for the Intellivision cartridge loader.
// Each map lists up to four file-word ranges and the CPU word address they land at.
package intv_cart_pkg;

  typedef struct packed {
    logic [23:0] start;
    logic [23:0] len;
    logic [15:0] base;
    logic        valid;
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_XLAT,
    ST_WRITE
  } state_t;

  localparam int ROM_INDEX_DEF = 1;
  localparam int NUM_MAPS      = 10;
  localparam int NUM_SEGS      = 4;

  function automatic seg_t mk_seg(input logic [23:0] s, input logic [23:0] l, input logic [15:0] b);
    return '{start: s, len: l, base: b, valid: 1'b1};
  endfunction

  localparam seg_t SEG_NONE = '0;

  // Unused slots are SEG_NONE so the search can skip them on the valid bit.
  localparam seg_t MAP_TABLE [NUM_MAPS][NUM_SEGS] = '{
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h1000, 16'hD000),
      mk_seg(24'h3000, 24'h1000, 16'hF000), SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h3000, 16'hD000),
      SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h3000, 16'h9000),
      mk_seg(24'h5000, 24'h1000, 16'hD000), SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h1000, 16'hD000),
      mk_seg(24'h3000, 24'h1000, 16'hF000), mk_seg(24'h4000, 24'h1000, 16'h9000)},
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h1000, 16'hD000),
      SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h3000, 16'h5000), mk_seg(24'h3000, 24'h3000, 16'h9000),
      SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h6000), SEG_NONE, SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h4800), SEG_NONE, SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h1000, 16'h5000), mk_seg(24'h1000, 24'h1000, 16'h7000),
      SEG_NONE, SEG_NONE},
    '{mk_seg(24'h0000, 24'h2000, 16'h5000), mk_seg(24'h2000, 24'h3000, 16'h9000),
      mk_seg(24'h5000, 24'h1000, 16'hD000), mk_seg(24'h6000, 24'h1000, 16'hF000)}
  };

endpackage

// File: rtl/intv_map_xlat.sv
// Combinational segment search: maps a 24-bit file word index to a CPU word address.
// The lowest-numbered matching segment wins; the parent registers the result.
module intv_map_xlat
  import intv_cart_pkg::*;
(
  input  logic [3:0]  map_i,
  input  logic [23:0] widx_i,
  output logic        hit_o,
  output logic [15:0] cpu_o
);

  logic [3:0]  map_idx;
  seg_t        seg;
  logic [23:0] off;

  // Walk from the last segment down so an earlier hit overrides a later one.
  always_comb begin
    hit_o   = 1'b0;
    cpu_o   = '0;
    seg     = SEG_NONE;
    off     = '0;
    map_idx = (map_i > 4'd9) ? 4'd0 : map_i;
    for (int i = NUM_SEGS - 1; i >= 0; i--) begin
      seg = MAP_TABLE[map_idx][i[1:0]];
      off = widx_i - seg.start;
      if (seg.valid && (widx_i >= seg.start) && (off < seg.len)) begin
        hit_o = 1'b1;
        cpu_o = seg.base + off[15:0];
      end
    end
  end

endmodule

// File: rtl/intv_cart_loader.sv
// Packs ioctl ROM bytes into big-endian words, maps them through the selected MAP table
// and writes them to cart RAM, back-pressuring hps_io while a write is outstanding.
module intv_cart_loader
  import intv_cart_pkg::*;
#(
  parameter int ROM_INDEX = ROM_INDEX_DEF,
  parameter int AUTO_MAP  = 0,
  parameter int ADDR_W    = 25
) (
  input  logic              clk_sys_i,
  input  logic              reset_n_i,
  input  logic              ioctl_download_i,
  input  logic [7:0]        ioctl_index_i,
  input  logic              ioctl_wr_i,
  input  logic [ADDR_W-1:0] ioctl_addr_i,
  input  logic [7:0]        ioctl_dout_i,
  output logic              ioctl_wait_o,
  input  logic [3:0]        map_sel_i,
  output logic              cart_req_o,
  input  logic              cart_ack_i,
  output logic [15:0]       cart_addr_o,
  output logic [15:0]       cart_data_o,
  output logic [15:0]       page_en_o,
  output logic              loading_o,
  output logic              load_done_o,
  output logic              map_overflow_o
);

  state_t            state_q;
  logic [3:0]        map_q;
  logic [7:0]        msb_q, lsb_q;
  logic [23:0]       widx_q;
  logic [15:0]       cpu_q, page_q;
  logic              req_q, wait_q, loading_q, done_q, ovf_q;
  logic              dl_q, end_q, pend_q;
  logic              skid_v_q;
  logic [7:0]        skid_data_q;
  logic [ADDR_W-1:0] skid_addr_q;

  logic              dl_fall, rom_start, end_now;
  logic              byte_vld;
  logic [7:0]        byte_data;
  logic [ADDR_W-1:0] byte_addr;
  logic [3:0]        map_d;
  logic              xlat_hit;
  logic [15:0]       xlat_cpu;
  logic              unused_idx;

  assign dl_fall    = ~ioctl_download_i & dl_q;
  assign rom_start  = ioctl_download_i & ~dl_q & (ioctl_index_i[5:0] == 6'(ROM_INDEX));
  assign end_now    = end_q | dl_fall;
  assign unused_idx = ^ioctl_index_i[7:6];

  // A byte held in the skid register is always older than a live strobe, so it goes first.
  assign byte_vld  = skid_v_q | ioctl_wr_i;
  assign byte_data = skid_v_q ? skid_data_q : ioctl_dout_i;
  assign byte_addr = skid_v_q ? skid_addr_q : ioctl_addr_i;
  assign map_d     = ((map_sel_i == 4'd0) || (map_sel_i > 4'd10)) ? 4'(AUTO_MAP) : map_sel_i - 4'd1;

  intv_map_xlat u_xlat (
    .map_i  (map_q),
    .widx_i (widx_q),
    .hit_o  (xlat_hit),
    .cpu_o  (xlat_cpu)
  );

  always_ff @(posedge clk_sys_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      map_q       <= '0;
      msb_q       <= '0;
      lsb_q       <= '0;
      widx_q      <= '0;
      cpu_q       <= '0;
      page_q      <= '0;
      req_q       <= 1'b0;
      wait_q      <= 1'b0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dl_q        <= ioctl_download_i;
      end_q       <= 1'b0;
      pend_q      <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
    end else begin
      dl_q   <= ioctl_download_i;
      done_q <= 1'b0;
      // A new ROM download seen mid-drain waits in pend_q until IDLE restarts it.
      if (state_q != ST_IDLE) begin
        end_q <= end_now;
        if (rom_start) pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (rom_start || pend_q) begin
            pend_q    <= 1'b0;
            page_q    <= '0;
            ovf_q     <= 1'b0;
            map_q     <= map_d;
            loading_q <= 1'b1;
            end_q     <= 1'b0;
            skid_v_q  <= 1'b0;
            state_q   <= ST_HI;
          end
        end
        ST_HI: begin
          skid_v_q <= skid_v_q & ioctl_wr_i;
          if (skid_v_q && ioctl_wr_i) begin
            skid_data_q <= ioctl_dout_i;
            skid_addr_q <= ioctl_addr_i;
          end
          if (byte_vld && !byte_addr[0]) begin
            msb_q   <= byte_data;
            widx_q  <= byte_addr[ADDR_W-1:1];
            state_q <= ST_LO;
          end else if (end_now) begin
            state_q   <= ST_IDLE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
            end_q     <= 1'b0;
            skid_v_q  <= 1'b0;
          end
        end
        ST_LO: begin
          skid_v_q <= skid_v_q & ioctl_wr_i;
          if (skid_v_q && ioctl_wr_i) begin
            skid_data_q <= ioctl_dout_i;
            skid_addr_q <= ioctl_addr_i;
          end
          if (byte_vld && byte_addr[0]) begin
            lsb_q   <= byte_data;
            widx_q  <= byte_addr[ADDR_W-1:1];
            wait_q  <= 1'b1;
            state_q <= ST_XLAT;
          end else begin
            // An even byte here restarts the word; a download end flushes it with a zero LSB.
            if (byte_vld) begin
              msb_q  <= byte_data;
              widx_q <= byte_addr[ADDR_W-1:1];
            end
            if (end_now) begin
              lsb_q   <= 8'h00;
              wait_q  <= 1'b1;
              state_q <= ST_XLAT;
            end
          end
        end
        ST_XLAT: begin
          if (ioctl_wr_i && !skid_v_q) begin
            skid_v_q    <= 1'b1;
            skid_data_q <= ioctl_dout_i;
            skid_addr_q <= ioctl_addr_i;
          end
          if (xlat_hit) begin
            cpu_q   <= xlat_cpu;
            req_q   <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            ovf_q   <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= ST_HI;
          end
        end
        ST_WRITE: begin
          if (ioctl_wr_i && !skid_v_q) begin
            skid_v_q    <= 1'b1;
            skid_data_q <= ioctl_dout_i;
            skid_addr_q <= ioctl_addr_i;
          end
          if (cart_ack_i) begin
            page_q[cpu_q[15:12]] <= 1'b1;
            req_q                <= 1'b0;
            wait_q               <= 1'b0;
            state_q              <= ST_HI;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ioctl_wait_o   = wait_q;
  assign cart_req_o     = req_q;
  assign cart_addr_o    = cpu_q;
  assign cart_data_o    = {msb_q, lsb_q};
  assign page_en_o      = page_q;
  assign loading_o      = loading_q;
  assign load_done_o    = done_q;
  assign map_overflow_o = ovf_q;

endmodule
